// File: rtl/toast_regfile.sv
// Integer register file: two combinational source reads with WB bypass,
// x0 hardwired to zero, and a registered debug read port.
module toast_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] WB_rd_addr_i,
  input  logic [XLEN-1:0]   WB_rd_wr_data_i,
  input  logic              WB_rd_wr_en_i,
  input  logic [ADDR_W-1:0] ID_rs1_addr_i,
  input  logic [ADDR_W-1:0] ID_rs2_addr_i,
  output logic [XLEN-1:0]   ID_rs1_data_o,
  output logic [XLEN-1:0]   ID_rs2_data_o,
  input  logic [ADDR_W-1:0] DBG_addr_i,
  output logic [XLEN-1:0]   DBG_data_o
);

  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic [XLEN-1:0] mem_d [NUM_REGS];
  logic [XLEN-1:0] dbg_q;
  logic [XLEN-1:0] dbg_d;
  logic            wr_en_c;

  // Read rule shared by both ID ports and the debug port (reset handled by caller).
  function automatic logic [XLEN-1:0] resolve(
    input logic [ADDR_W-1:0] addr,
    input logic [XLEN-1:0]   stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]   wdata
  );
    logic [XLEN-1:0] res;
    res = stored;
    if (addr == '0) begin
      res = '0;
    end else if (we && (waddr == addr)) begin
      res = wdata;
    end
    return res;
  endfunction

  assign wr_en_c = WB_rd_wr_en_i && (WB_rd_addr_i != '0);

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en_c) begin
      mem_d[WB_rd_addr_i] = WB_rd_wr_data_i;
    end
    mem_d[0] = '0;
  end

  always_comb begin
    ID_rs1_data_o = '0;
    ID_rs2_data_o = '0;
    dbg_d         = '0;
    if (!rst_i) begin
      ID_rs1_data_o = resolve(ID_rs1_addr_i, mem_q[ID_rs1_addr_i], WB_rd_wr_en_i,
                              WB_rd_addr_i, WB_rd_wr_data_i);
      ID_rs2_data_o = resolve(ID_rs2_addr_i, mem_q[ID_rs2_addr_i], WB_rd_wr_en_i,
                              WB_rd_addr_i, WB_rd_wr_data_i);
      dbg_d         = resolve(DBG_addr_i, mem_q[DBG_addr_i], WB_rd_wr_en_i,
                              WB_rd_addr_i, WB_rd_wr_data_i);
    end
  end

  // Reset wipes the whole array and drops any concurrent write.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      mem_q[i] <= rst_i ? '0 : mem_d[i];
    end
    dbg_q <= dbg_d;
  end

  assign DBG_data_o = dbg_q;

endmodule

// File: tb/tb_toast_regfile.sv
// Self-checking bench for toast_regfile: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_toast_regfile;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              wb_en;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_data;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] model [NREGS];
  logic [XLEN-1:0] dbg_exp;

  toast_regfile #(.XLEN(XLEN), .NUM_REGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .WB_rd_addr_i    (wb_addr),
    .WB_rd_wr_data_i (wb_data),
    .WB_rd_wr_en_i   (wb_en),
    .ID_rs1_addr_i   (rs1_addr),
    .ID_rs2_addr_i   (rs2_addr),
    .ID_rs1_data_o   (rs1_data),
    .ID_rs2_data_o   (rs2_data),
    .DBG_addr_i      (dbg_addr),
    .DBG_data_o      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a read of addr should return right now, given the driven inputs.
  function automatic logic [XLEN-1:0] exp_read(input logic [ADDR_W-1:0] addr);
    if (rst) return '0;
    if (addr == 0) return '0;
    if (wb_en && wb_addr == addr) return wb_data;
    return model[addr];
  endfunction

  // Advance one edge, keeping the model and expected debug value in step.
  task automatic tick();
    logic [XLEN-1:0] d;
    d = exp_read(dbg_addr);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (wb_en && wb_addr != 0) begin
      model[wb_addr] = wb_data;
    end
    dbg_exp = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    tick(); tick();
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0; rs1_addr = 5'd5; #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_prewrite: got %h want %h", rs1_data, 32'hDEADBEEF);
    end
    rst = 1'b1; #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL reset_forced_read: got %h want 0", rs1_data);
    end
    tick();
    rst = 1'b0; dbg_addr = 5'd5; #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL reset_clear_rs1: got %h want 0", rs1_data);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL reset_dbg_zero: got %h want 0", dbg_data);
    end
    tick();
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL reset_dbg_x5: got %h want 0", dbg_data);
    end
  endtask

  task automatic test_x0();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0; #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      errors++; $display("FAIL x0_same_cycle: got %h/%h want 0/0", rs1_data, rs2_data);
    end
    tick();
    wb_en = 1'b0; #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      errors++; $display("FAIL x0_after: got %h/%h want 0/0", rs1_data, rs2_data);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL x0_dbg: got %h want 0", dbg_data);
    end
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h0BADCAFE;
    tick();
    wb_addr = 5'd10; wb_data = 32'h12345678;
    tick();
    wb_en = 1'b0; rs2_addr = 5'd10; rs1_addr = 5'd11; #1;
    checks++;
    if (rs2_data !== 32'h12345678) begin
      errors++; $display("FAIL write_read_x10: got %h want %h", rs2_data, 32'h12345678);
    end
    checks++;
    if (rs1_data !== 32'h0BADCAFE) begin
      errors++; $display("FAIL write_read_x11: got %h want %h", rs1_data, 32'h0BADCAFE);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1;
    tick();
    wb_data = 32'hCAFEF00D; rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
    checks++;
    if (rs1_data !== 32'hCAFEF00D || rs2_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bypass_same_cycle: got %h/%h want %h", rs1_data, rs2_data, 32'hCAFEF00D);
    end
    tick();
    wb_en = 1'b0; #1;
    checks++;
    if (rs1_data !== 32'hCAFEF00D || rs2_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL bypass_after: got %h/%h want %h", rs1_data, rs2_data, 32'hCAFEF00D);
    end
  endtask

  task automatic test_write_during_reset();
    rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAAAA5555; rs1_addr = 5'd3; #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL rst_write_during: got %h want 0", rs1_data);
    end
    tick();
    rst = 1'b0; wb_en = 1'b0; #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++; $display("FAIL rst_write_dropped: got %h want 0", rs1_data);
    end
  endtask

  task automatic test_back_to_back();
    dbg_addr = 5'd31; wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'h1;
    tick();
    checks++;
    if (dbg_data !== 32'h1) begin
      errors++; $display("FAIL b2b_dbg_first: got %h want 1", dbg_data);
    end
    wb_data = 32'h2; rs1_addr = 5'd31; #1;
    checks++;
    if (rs1_data !== 32'h2) begin
      errors++; $display("FAIL b2b_rs1_bypass: got %h want 2", rs1_data);
    end
    tick();
    checks++;
    if (dbg_data !== 32'h2) begin
      errors++; $display("FAIL b2b_dbg_second: got %h want 2", dbg_data);
    end
    wb_en = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [XLEN-1:0] e1, e2;
    for (int k = 0; k < n; k++) begin
      rst      = ($urandom_range(0, 99) < 3);
      wb_en    = $urandom_range(0, 1);
      wb_addr  = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      wb_data  = $urandom;
      rs1_addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      rs2_addr = ($urandom_range(0, 2) == 0) ? rs1_addr : ADDR_W'($urandom);
      dbg_addr = ($urandom_range(0, 1) == 1) ? wb_addr : ADDR_W'($urandom);
      #1;
      e1 = exp_read(rs1_addr);
      e2 = exp_read(rs2_addr);
      checks++;
      if (rs1_data !== e1) begin
        errors++; $display("FAIL rand_rs1[%0d]: addr %0d got %h want %h", k, rs1_addr, rs1_data, e1);
      end
      checks++;
      if (rs2_data !== e2) begin
        errors++; $display("FAIL rand_rs2[%0d]: addr %0d got %h want %h", k, rs2_addr, rs2_data, e2);
      end
      tick();
      checks++;
      if (dbg_data !== dbg_exp) begin
        errors++; $display("FAIL rand_dbg[%0d]: got %h want %h", k, dbg_data, dbg_exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    dbg_exp = '0;
    test_reset();
    test_x0();
    test_write_read();
    test_bypass();
    test_write_during_reset();
    test_back_to_back();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toast_regfile.md
Name: toast_regfile

Overview:
- Integer register file on the receiving end of the writeback interface. It accepts the write address, write data and write enable driven by the WB stage, and serves the two source-operand reads for the ID stage.
- Provides x0 hardwired to zero and write-to-read bypass, so ID sees a value in the same cycle WB writes it.
- Includes a registered debug read port for bench and trace inspection.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers, including x0.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- WB_rd_addr_i  input  ADDR_W  destination register address from WB.
- WB_rd_wr_data_i  input  XLEN  writeback data from WB.
- WB_rd_wr_en_i  input  1  write strobe from WB.
- ID_rs1_addr_i  input  ADDR_W  source 1 address.
- ID_rs2_addr_i  input  ADDR_W  source 2 address.
- ID_rs1_data_o  output  XLEN  source 1 data (combinational).
- ID_rs2_data_o  output  XLEN  source 2 data (combinational).
- DBG_addr_i  input  ADDR_W  debug read address.
- DBG_data_o  output  XLEN  debug read data, registered, 1-cycle latency.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high and fixed as such.
- Storage: NUM_REGS x XLEN array. Entry 0 is never written and always reads as 0.
- Reset:
  - With rst_i high at a rising edge, every array entry becomes 0 and DBG_data_o becomes 0.
  - A write presented in that same cycle is dropped.
  - While rst_i is high, ID_rs1_data_o and ID_rs2_data_o are forced to 0.
- Reset mid-operation: asserting rst_i on any cycle discards all stored state, with no partial retention. On the first cycle after deassertion, every register reads as 0.
- Write:
  - Condition: WB_rd_wr_en_i=1, WB_rd_addr_i!=0 and rst_i=0.
  - Effect: array[WB_rd_addr_i] <= WB_rd_wr_data_i at the rising edge.
  - A write to address 0 is silently ignored.
  - Write latency is 1 edge.
- Read (per port, combinational), in priority order:
  1. rst_i=1 -> 0.
  2. rs_addr==0 -> 0.
  3. WB_rd_wr_en_i=1 and WB_rd_addr_i==rs_addr -> WB_rd_wr_data_i (bypass of the in-flight write).
  4. Otherwise -> array[rs_addr].
- Simultaneous reads: both ports may hit the same address, or the same address being written. Both then return identical, bypassed data.
- Debug port:
  - On each rising edge with rst_i=0: DBG_data_o <= the read-rule result for DBG_addr_i, including bypass of a same-cycle write.
  - DBG_data_o therefore equals the post-edge content of that register.
- No handshake: writes are single-cycle strobes with no backpressure, and no stall input exists.
- Width rules: addresses are taken as full ADDR_W bits with no truncation. Data is stored and returned unmodified at XLEN bits.
- Out-of-range addresses are impossible by parameter constraint.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, assert rst_i for 1 cycle, release, read rs1=5 -> 0x00000000. DBG_addr=5 gives 0 one cycle later.
- x0 immutability: write en=1, addr=0, data=0xFFFFFFFF, then read rs1=0 and rs2=0 -> both 0. The following cycle reads 0 again.
- Write then read: write 0x12345678 to x10 at edge N, then read rs2=10 at N+1 with en=0 -> 0x12345678. rs1=11 returns its prior value, untouched.
- Same-cycle bypass: x7 holds 0x1. In one cycle drive en=1, addr=7, data=0xCAFEF00D with rs1=rs2=7 -> both outputs show 0xCAFEF00D combinationally. After the edge, with en=0, they still read 0xCAFEF00D.
- Write during reset: rst_i=1 with en=1, addr=3, data=0xAAAA5555 -> rs1=3 reads 0 during reset and 0 after release. The write was dropped.
- Back-to-back writes plus debug: write x31=0x1 at edge N and x31=0x2 at edge N+1 with DBG_addr=31 -> DBG_data_o=0x1 after N, 0x2 after N+1. rs1=31 during the second write cycle shows 0x2 via bypass.
